// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC operand feeder.
package mac_pkg;

   localparam int unsigned OP_W  = 8;
   localparam int unsigned ACC_W = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0] x1;
      logic [OP_W-1:0] x2;
   } pair_t;

endpackage

// File: rtl/mac_opfifo.sv
// Operand-pair FIFO with show-ahead read; pointers wrap modulo DEPTH.
module mac_opfifo
   import mac_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  push,
   input  pair_t wdata,
   input  logic  pop,
   output pair_t rdata,
   output logic  full,
   output logic  empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   pair_t          mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr];

   // Storage array: written on accepted pushes only, contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mac_feeder.sv
// Feeds queued operand pairs to a MAC for a job of len pairs and captures the result.
module mac_feeder
   import mac_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned MAC_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_x1,
   input  logic [OP_W-1:0]  in_x2,
   input  logic             start,
   input  logic [4:0]       len,
   output logic [OP_W-1:0]  x1,
   output logic [OP_W-1:0]  x2,
   output logic             mac_rst,
   input  logic [ACC_W-1:0] y,
   output logic             res_valid,
   output logic [ACC_W-1:0] res_data,
   output logic             busy
);

   localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   state_t         state;
   state_t         state_next;
   logic [4:0]     remaining;
   logic [DW-1:0]  dcnt;
   logic           rdy;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   pair_t          head;
   pair_t          wdata;

   // rdy stays low through reset so in_ready and mac_rst show their reset values.
   assign in_ready = rdy & ~full;
   assign push     = in_valid & in_ready;
   assign wdata    = '{x1: in_x1, x2: in_x2};

   mac_opfifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_CLEAR;
         S_CLEAR: state_next = S_ISSUE;
         S_ISSUE: if (remaining == '0) state_next = S_DRAIN;
         S_DRAIN: if (dcnt == '0) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State-decoded outputs and FIFO pop request.
   always_comb begin
      busy      = (state != S_IDLE);
      mac_rst   = ~rdy | (state == S_CLEAR);
      res_valid = (state == S_DONE);
      pop       = (state == S_ISSUE) && (remaining != '0) && !empty;
   end

   // Operand registers: a popped pair is driven next cycle, otherwise zeros.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x1  <= '0;
         x2  <= '0;
         rdy <= 1'b0;
      end else begin
         rdy <= 1'b1;
         if (pop) begin
            x1 <= head.x1;
            x2 <= head.x2;
         end else begin
            x1 <= '0;
            x2 <= '0;
         end
      end
   end

   // Job counters: remaining pairs, drain timer and result capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         remaining <= '0;
         dcnt      <= '0;
         res_data  <= '0;
      end else begin
         if (state == S_IDLE && start) remaining <= len;
         else if (pop)                 remaining <= remaining - 5'd1;
         if (state == S_ISSUE)
            dcnt <= DW'(MAC_LAT - 1);
         else if (state == S_DRAIN && dcnt != '0)
            dcnt <= dcnt - 1'b1;
         // Capture on entry to DONE so res_data is valid alongside res_valid.
         if (state == S_DRAIN && dcnt == '0) res_data <= y;
      end
   end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed testbench for mac_feeder with a behavioural single-cycle MAC.
module tb_mac_feeder;
   import mac_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_x1;
   logic [7:0]  in_x2;
   logic        start;
   logic [4:0]  len;
   logic [7:0]  x1;
   logic [7:0]  x2;
   logic        mac_rst;
   logic [9:0]  y = '0;
   logic        res_valid;
   logic [9:0]  res_data;
   logic        busy;

   int          n_chk = 0;
   int          n_pass = 0;
   int          rv_count = 0;
   int          rv0;
   int          idx;
   logic        acc;
   logic [15:0] issued[$];
   logic [15:0] prod;

   always #5 clk = ~clk;

   mac_feeder #(
      .DEPTH(4),
      .MAC_LAT(1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x1     (in_x1),
      .in_x2     (in_x2),
      .start     (start),
      .len       (len),
      .x1        (x1),
      .x2        (x2),
      .mac_rst   (mac_rst),
      .y         (y),
      .res_valid (res_valid),
      .res_data  (res_data),
      .busy      (busy)
   );

   // MAC model: one cycle from operands to accumulator, wraps at 10 bits.
   assign prod = 16'(x1) * 16'(x2);
   always @(posedge clk) begin
      if (mac_rst) y <= '0;
      else         y <= y + prod[9:0];
   end

   // Monitor: record issued pairs and result pulses.
   always @(negedge clk) begin
      if (reset) begin
         if (res_valid) rv_count++;
         if (x1 != 0 || x2 != 0) issued.push_back({x1, x2});
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      in_x1    = a;
      in_x2    = b;
      chk("push_ready", {31'd0, in_ready}, 1);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic start_job(input logic [4:0] l);
      start = 1'b1;
      len   = l;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_res(input string tag, input logic [9:0] exp);
      for (int i = 0; i < 40 && !res_valid; i++) cyc();
      chk({tag, "_valid"}, {31'd0, res_valid}, 1);
      chk({tag, "_data"}, {22'd0, res_data}, {22'd0, exp});
      cyc();
      chk({tag, "_pulse_end"}, {31'd0, res_valid}, 0);
      chk({tag, "_idle"}, {31'd0, busy}, 0);
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_x1 = '0; in_x2 = '0; start = 1'b0; len = '0;

      // Reset values
      #12;
      chk("rst_x1", {24'd0, x1}, 0);
      chk("rst_x2", {24'd0, x2}, 0);
      chk("rst_mac_rst", {31'd0, mac_rst}, 1);
      chk("rst_res_valid", {31'd0, res_valid}, 0);
      chk("rst_res_data", {22'd0, res_data}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      @(negedge clk);
      reset = 1'b1;
      cyc();
      chk("post_rst_mac_rst", {31'd0, mac_rst}, 0);
      chk("post_rst_in_ready", {31'd0, in_ready}, 1);

      // Scenario 1: three (32,2) pairs, cycle-exact
      repeat (3) push(8'd32, 8'd2);
      issued.delete();
      rv0 = rv_count;
      start_job(5'd3);
      chk("s1_clear_busy", {31'd0, busy}, 1);
      chk("s1_clear_mac_rst", {31'd0, mac_rst}, 1);
      chk("s1_clear_x1", {24'd0, x1}, 0);
      cyc();
      chk("s1_issue_mac_rst", {31'd0, mac_rst}, 0);
      chk("s1_issue_x1_0", {24'd0, x1}, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("s1_x1", {24'd0, x1}, 32);
         chk("s1_x2", {24'd0, x2}, 2);
      end
      cyc();
      chk("s1_drain_x1", {24'd0, x1}, 0);
      chk("s1_drain_valid", {31'd0, res_valid}, 0);
      cyc();
      chk("s1_done_valid", {31'd0, res_valid}, 1);
      chk("s1_done_data", {22'd0, res_data}, 192);
      cyc();
      chk("s1_after_valid", {31'd0, res_valid}, 0);
      chk("s1_after_busy", {31'd0, busy}, 0);
      chk("s1_pulse_count", rv_count - rv0, 1);
      chk("s1_res_hold", {22'd0, res_data}, 192);

      // Scenario 2: stall on empty FIFO; a start while busy is ignored
      issued.delete();
      start_job(5'd2);
      cyc();
      cyc();
      chk("s2_stall_x1", {24'd0, x1}, 0);
      chk("s2_stall_x2", {24'd0, x2}, 0);
      chk("s2_stall_busy", {31'd0, busy}, 1);
      push(8'd5, 8'd4);
      start = 1'b1;
      len   = 5'd7;
      cyc();
      start = 1'b0;
      push(8'd1, 8'd1);
      wait_res("s2", 10'd21);
      chk("s2_n_issued", issued.size(), 2);
      chk("s2_pair0", {16'd0, issued[0]}, 32'h0504);
      chk("s2_pair1", {16'd0, issued[1]}, 32'h0101);

      // Scenario 3: six pairs offered into a 4-deep FIFO, then one 6-pair job
      issued.delete();
      idx = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         in_x1 = 8'(2 * idx + 1);
         in_x2 = 8'(2 * idx + 2);
         chk("s3_fill_ready", {31'd0, in_ready}, 1);
         cyc();
         idx++;
      end
      in_x1 = 8'(2 * idx + 1);
      in_x2 = 8'(2 * idx + 2);
      chk("s3_full_ready", {31'd0, in_ready}, 0);
      cyc();
      chk("s3_full_ready2", {31'd0, in_ready}, 0);
      start = 1'b1;
      len   = 5'd6;
      acc   = in_ready;
      cyc();
      if (acc) idx++;
      start = 1'b0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         in_x1 = 8'(2 * idx + 1);
         in_x2 = 8'(2 * idx + 2);
         acc   = in_ready;
         cyc();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("s3_all_pushed", idx, 6);
      wait_res("s3", 10'd322);
      chk("s3_n_issued", issued.size(), 6);
      for (int i = 0; i < 6; i++)
         chk("s3_order", {16'd0, issued[i]}, {16'd0, 8'(2 * i + 1), 8'(2 * i + 2)});

      // Scenario 5: len = 0 runs CLEAR/ISSUE/DRAIN/DONE with no issue
      issued.delete();
      start_job(5'd0);
      chk("s5_clear_mac_rst", {31'd0, mac_rst}, 1);
      cyc();
      chk("s5_busy", {31'd0, busy}, 1);
      cyc();
      chk("s5_drain_valid", {31'd0, res_valid}, 0);
      cyc();
      chk("s5_done_valid", {31'd0, res_valid}, 1);
      chk("s5_done_data", {22'd0, res_data}, 0);
      cyc();
      chk("s5_idle", {31'd0, busy}, 0);
      chk("s5_n_issued", issued.size(), 0);

      // Leftover pairs stay queued for the next job
      push(8'd2, 8'd3);
      push(8'd4, 8'd5);
      start_job(5'd1);
      wait_res("keep1", 10'd6);
      start_job(5'd1);
      wait_res("keep2", 10'd20);

      // Scenario 4: accumulator wrap, FIFO full
      repeat (4) push(8'd255, 8'd255);
      chk("s4_full_ready", {31'd0, in_ready}, 0);
      start_job(5'd4);
      wait_res("s4", 10'd4);

      // Scenario 6: reset mid-job
      push(8'd7, 8'd7);
      push(8'd7, 8'd7);
      start_job(5'd2);
      cyc();
      cyc();
      chk("s6_issue_x1", {24'd0, x1}, 7);
      rv0 = rv_count;
      #2;
      reset = 1'b0;
      #1;
      chk("s6_rst_x1", {24'd0, x1}, 0);
      chk("s6_rst_x2", {24'd0, x2}, 0);
      chk("s6_rst_mac_rst", {31'd0, mac_rst}, 1);
      chk("s6_rst_res_valid", {31'd0, res_valid}, 0);
      chk("s6_rst_res_data", {22'd0, res_data}, 0);
      chk("s6_rst_busy", {31'd0, busy}, 0);
      chk("s6_rst_in_ready", {31'd0, in_ready}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      issued.delete();
      cyc();
      chk("s6_post_in_ready", {31'd0, in_ready}, 1);
      chk("s6_post_mac_rst", {31'd0, mac_rst}, 0);
      chk("s6_no_result", rv_count - rv0, 0);
      push(8'd3, 8'd3);
      start_job(5'd1);
      wait_res("s6", 10'd9);
      chk("s6_n_issued", issued.size(), 1);
      chk("s6_pair", {16'd0, issued[0]}, 32'h0303);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
